// File: rtl/wb_bus_guard.sv
// wb_bus_guard -- Wishbone request guard between the management-core master
// and the user-project interconnect.
//
// Every request is registered. In-window requests are forwarded and bounded
// by a timeout. Out-of-window or timed-out requests get a single ack that
// carries ERR_DATA. Only one transaction is outstanding at a time.
//
// Optional build macro: WB_GUARD_STATUS_EN
//   When defined, adds saturating error and timeout counters. These are read
//   (or cleared by a write) through a local register at STATUS_ADR.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   wbs_*_i / wbs_*_o          upstream slave side (from the CPU master)
//   m_*_o / m_*_i              downstream master side (to the interconnect)
//   timeout_o                  one-cycle pulse when a forwarded access times out
module wb_bus_guard #(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter int          WIN_BITS   = 24,
  parameter int          TIMEOUT    = 256,
  parameter logic [31:0] ERR_DATA   = 32'hBADD_CAFE,
  parameter logic [31:0] STATUS_ADR = 32'h30FF_FFFC
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_dat_o,
  output logic [31:0] m_adr_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  output logic        timeout_o
);

  localparam int            CW   = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

`ifdef WB_GUARD_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          ack_reg, ack_next;
  logic          to_reg, to_next;
  logic [31:0]   rdat_reg, rdat_next;
  logic          stb_reg, stb_next;
  logic          we_reg, we_next;
  logic [3:0]    sel_reg, sel_next;
  logic [31:0]   dat_reg, dat_next;
  logic [31:0]   adr_reg, adr_next;

  logic req, in_win, is_status;
  logic [31:0] status_word;

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign in_win    = (wbs_adr_i[31:WIN_BITS] == BASE_ADR[31:WIN_BITS]);
  // Constant-false in the default build, so the status branch folds away.
  assign is_status = STATUS_EN && (wbs_adr_i == STATUS_ADR);

`ifdef WB_GUARD_STATUS_EN
  logic [15:0] err_cnt_reg, err_cnt_next;
  logic [15:0] to_cnt_reg, to_cnt_next;
  assign status_word = {err_cnt_reg, to_cnt_reg};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_cnt_reg <= '0;
      to_cnt_reg  <= '0;
    end else begin
      err_cnt_reg <= err_cnt_next;
      to_cnt_reg  <= to_cnt_next;
    end
  end
`else
  assign status_word = '0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ack_reg   <= 1'b0;
      to_reg    <= 1'b0;
      rdat_reg  <= '0;
      stb_reg   <= 1'b0;
      we_reg    <= 1'b0;
      sel_reg   <= '0;
      dat_reg   <= '0;
      adr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= ack_next;
      to_reg    <= to_next;
      rdat_reg  <= rdat_next;
      stb_reg   <= stb_next;
      we_reg    <= we_next;
      sel_reg   <= sel_next;
      dat_reg   <= dat_next;
      adr_reg   <= adr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ack_next   = 1'b0;
    to_next    = 1'b0;
    rdat_next  = rdat_reg;
    stb_next   = stb_reg;
    we_next    = we_reg;
    sel_next   = sel_reg;
    dat_next   = dat_reg;
    adr_next   = adr_reg;
`ifdef WB_GUARD_STATUS_EN
    err_cnt_next = err_cnt_reg;
    to_cnt_next  = to_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (in_win && !is_status) begin
            we_next    = wbs_we_i;
            sel_next   = wbs_sel_i;
            dat_next   = wbs_dat_i;
            adr_next   = wbs_adr_i;
            stb_next   = 1'b1;
            cnt_next   = '0;
            state_next = FWD;
          end else if (in_win) begin
            // Local status register: answered without forwarding.
            rdat_next  = wbs_we_i ? 32'h0 : status_word;
            ack_next   = 1'b1;
            state_next = RESP;
`ifdef WB_GUARD_STATUS_EN
            if (wbs_we_i) begin
              err_cnt_next = '0;
              to_cnt_next  = '0;
            end
`endif
          end else begin
            rdat_next  = ERR_DATA;
            ack_next   = 1'b1;
            state_next = RESP;
`ifdef WB_GUARD_STATUS_EN
            if (err_cnt_reg != 16'hFFFF) err_cnt_next = err_cnt_reg + 16'd1;
`endif
          end
        end
      end
      FWD: begin
        // Master abort outranks a same-cycle slave ack; no response is given.
        if (!wbs_cyc_i) begin
          stb_next   = 1'b0;
          state_next = IDLE;
        end else if (m_ack_i) begin
          rdat_next  = m_dat_i;
          stb_next   = 1'b0;
          ack_next   = 1'b1;
          state_next = RESP;
        end else if (cnt_reg == LAST) begin
          rdat_next  = ERR_DATA;
          stb_next   = 1'b0;
          ack_next   = 1'b1;
          to_next    = 1'b1;
          state_next = RESP;
`ifdef WB_GUARD_STATUS_EN
          if (to_cnt_reg != 16'hFFFF) to_cnt_next = to_cnt_reg + 16'd1;
`endif
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RESP: begin
        // Return to IDLE without sampling, so a held strobe is not re-issued.
        state_next = IDLE;
      end
      default: begin
        stb_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = rdat_reg;
  assign m_stb_o   = stb_reg;
  assign m_cyc_o   = stb_reg;
  assign m_we_o    = we_reg;
  assign m_sel_o   = sel_reg;
  assign m_dat_o   = dat_reg;
  assign m_adr_o   = adr_reg;
  assign timeout_o = to_reg;

endmodule
